// File: rtl/weight_sram_loader.sv
// Write-side controller for the weight SRAM: turns a valid/ready word stream
// into sequential SRAM word writes, filling columns 0..COLS-1 of each row in turn.
module weight_sram_loader #(
    parameter int ROWS = 32,
    parameter int COLS = 72,
    parameter int DW   = 32,
    localparam int RW  = $clog2(ROWS),
    localparam int CW  = $clog2(COLS),
    localparam int NW  = RW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] start_row,
    input  logic [NW-1:0] num_rows,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [RW-1:0] sram_A_row,
    output logic [CW-1:0] sram_A_col,
    output logic [DW-1:0] sram_D
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [NW-1:0] left_q, left_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ceb_q, ceb_d;
    logic          web_q, web_d;
    logic [RW-1:0] arow_q, arow_d;
    logic [CW-1:0] acol_q, acol_d;
    logic [DW-1:0] data_q, data_d;

    logic hs, legal, start_ok, last_col, last_word;

    assign legal     = (num_rows != '0) && (num_rows <= NW'(ROWS));
    assign start_ok  = (state_q == IDLE) && start && legal;
    assign hs        = in_valid && in_ready;
    assign last_col  = (col_q == CW'(COLS - 1));
    assign last_word = last_col && (left_q == NW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: begin
                if (abort)                 state_d = IDLE;
                else if (hs && last_word)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q != IDLE);
    end

    // A handshake coinciding with abort still writes its word; abort only blocks done.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        left_d = left_q;
        arow_d = arow_q;
        acol_d = acol_q;
        data_d = data_q;
        ceb_d  = ~hs;
        web_d  = ~hs;
        done_d = hs && last_word && !abort;
        err_d  = start && ((state_q != IDLE) || !legal);
        if (start_ok) begin
            row_d  = start_row;
            col_d  = '0;
            left_d = num_rows;
        end else if (hs) begin
            arow_d = row_q;
            acol_d = col_q;
            data_d = in_data;
            if (last_col) begin
                col_d  = '0;
                row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                left_d = left_q - NW'(1);
            end else begin
                col_d  = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            left_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ceb_q  <= 1'b1;
            web_q  <= 1'b1;
            arow_q <= '0;
            acol_q <= '0;
            data_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            left_q <= left_d;
            done_q <= done_d;
            err_q  <= err_d;
            ceb_q  <= ceb_d;
            web_q  <= web_d;
            arow_q <= arow_d;
            acol_q <= acol_d;
            data_q <= data_d;
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign sram_ceb   = ceb_q;
    assign sram_web   = web_q;
    assign sram_A_row = arow_q;
    assign sram_A_col = acol_q;
    assign sram_D     = data_q;

endmodule

// File: doc/weight_sram_loader.md
# weight_sram_loader

Write-side controller for the 32 x 2304-bit weight SRAM. It accepts a stream of 32-bit weight words over a valid/ready handshake and converts each accepted word into one SRAM word write. The controller drives the SRAM's ceb/web/A_row/A_col/D port, fills columns 0..71 of a row, then advances to the next row. It sits between the host/DMA weight stream and the weight SRAM.

## Interface

Parameters:
- ROWS, 32, SRAM rows; row address width 5
- COLS, 72, 32-bit words per row (2304/32); column address width 7
- DW, 32, word width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle load request; honoured only in IDLE
- start_row  in  5  first row to fill
- num_rows  in  6  rows to fill; legal range 1..32
- abort  in  1  cancel the load in progress
- in_valid  in  1  in_data is valid
- in_data  in  32  weight word
- in_ready  out  1  word accepted when in_valid && in_ready at a rising edge
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse on a rejected start
- sram_ceb  out  1  SRAM chip enable, active low
- sram_web  out  1  SRAM write enable, active low
- sram_A_row  out  5  row address
- sram_A_col  out  7  column word address
- sram_D  out  32  write data

## Operation

- **FSM states:** IDLE, LOAD, DONE.
- **IDLE, start=1, num_rows in 1..32:**
  - Load row_ptr=start_row, col_ptr=0, rows_left=num_rows.
  - Go to LOAD.
- **IDLE, start=1, num_rows=0 or >32:**
  - Pulse err for one cycle.
  - Stay in IDLE.
- **start while in LOAD or DONE:** ignored; err pulses for one cycle; the load in progress is unaffected.
- **LOAD:**
  - in_ready=1. It is a decode of the state register and does not depend on in_valid.
  - On each handshake, the next edge registers sram_ceb=0, sram_web=0, sram_A_row=row_ptr, sram_A_col=col_ptr, sram_D=in_data.
  - col_ptr increments on each handshake. On col_ptr=71 it wraps to 0, row_ptr increments modulo 32, and rows_left decrements.
- **Last word** (col_ptr=71 and rows_left=1 at handshake): go to DONE; done is registered to 1 on that same edge.
- **DONE:** in_ready=0. Go to IDLE on the next edge.
- **Cycles with no handshake:** sram_ceb=1 and sram_web=1 (SRAM idle). Address and data registers hold their last values.
- **Row wrap:** start_row + num_rows > 32 wraps modulo 32; e.g. start_row=30, num_rows=4 fills rows 30, 31, 0, 1.
- **abort in LOAD:**
  - Next edge: IDLE, sram_ceb=1, no done.
  - If a handshake coincides with abort, that word is still written (it is presented on the SRAM pins for one cycle). No later word is accepted.
  - abort in IDLE or DONE has no effect.
- **Priority in LOAD:** abort > handshake.
- **Reset values:**
  - state=IDLE.
  - in_ready=0, busy=0, done=0, err=0.
  - sram_ceb=1, sram_web=1.
  - sram_A_row=0, sram_A_col=0, sram_D=0.
  - Internal pointers and counters are 0.
- **Reset mid-load:** the load is dropped immediately (asynchronously); sram_ceb goes to 1 without waiting for a clock edge. A write in flight is not guaranteed.

## Timing

- **Handshake-to-write latency:**
  - A word is accepted at edge k.
  - The SRAM pins show the write between edges k and k+1.
  - The SRAM captures it at edge k+1.
- **Throughput:** one word per cycle with in_valid held high. A full 32-row load takes 2304 cycles in LOAD plus 1 cycle in DONE.
- **busy:**
  - Rises on the edge that accepts start.
  - Falls on the edge that leaves DONE (or on abort/reset).
- **done:**
  - High for exactly the cycle in which the final write is on the SRAM pins.
  - It can be used as "last write issued"; the data is in the SRAM after the following edge.
- **Earliest back-to-back start:** a new start is accepted in the first IDLE cycle after DONE.
- **in_valid outside LOAD:** ignored; no write occurs.

## Test plan

1. **Single-row load:**
   - Stimulus: start_row=3, num_rows=1; stream 72 words 0x00000000..0x00000047 with in_valid held high.
   - Required: 72 consecutive writes to row 3, cols 0..71, each sram_D equal to its column index; done high with the col-71 write; busy low 2 cycles after the last handshake; read-back of row 3 matches.
2. **Row wrap and back-pressure:**
   - Stimulus: start_row=30, num_rows=4; in_valid toggled at random.
   - Required: writes land in rows 30, 31, 0, 1 in order; sram_ceb=1 in every cycle without a handshake; exactly 288 writes.
3. **Illegal starts:**
   - Stimulus: num_rows=0, then num_rows=33, then start pulsed during a load.
   - Required: err pulses one cycle each time; state and the in-progress load are unaffected.
4. **Abort:**
   - Stimulus: abort asserted after 100 handshakes, coincident with the 101st handshake.
   - Required: 101 writes (row start_row, cols 0..71, then row start_row+1, cols 0..28); IDLE next cycle; no done.
5. **Async reset mid-load:**
   - Stimulus: rst asserted between edges during LOAD.
   - Required: sram_ceb=1, in_ready=0, busy=0 immediately; after release, a fresh load with start_row=0, num_rows=1 completes normally.
